rr_sel_mux: RTL and testbench
=============================

Name: rr_sel_mux

Overview:
- Parametrised N:1 datapath selector with a registered output stage and valid/ready handshake.
- Generalises the team's fixed 2:1 32-bit select: configurable width and input count, plus a round-robin arbitration mode beside the fixed-select mode.
- Used in the CPU datapath where several producers share one sink, e.g. write-back source selection and a shared memory port.

Parameters:
- DATA_W, 32, width of each data channel in bits.
- NUM_IN, 4, number of input channels; legal range 2..16.
- SEL_W, 2, selector width; must equal ceil(log2(NUM_IN)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- mode  input  1  0 = fixed select by sel; 1 = round-robin.
- sel  input  SEL_W  channel index, used only in mode 0.
- in_valid  input  NUM_IN  per-channel valid.
- in_data  input  NUM_IN*DATA_W  flattened data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  NUM_IN  per-channel ready; at most one bit is high.
- out_valid  output  1  registered output valid.
- out_data  output  DATA_W  registered selected data.
- out_src  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  sink ready.

Behaviour:
- Reset: one clock with rst_n=0 forces the following registers.
  - out_valid=0, out_data=0, out_src=0, rr_ptr=0.
  - Reset asserted mid-transfer discards the held word, with no partial update.
- load = !out_valid || out_ready. This gives full throughput of one word per cycle with no bubble.
- Grant selection is combinational and evaluated every cycle.
  - mode 0: the grant is sel when sel < NUM_IN and in_valid[sel]=1. Otherwise there is no grant. Out-of-range sel never grants.
  - mode 1: the grant is the first index with in_valid set, searching rr_ptr, rr_ptr+1, … and wrapping modulo NUM_IN. No valid input means no grant.
- in_ready[g] = load for the granted g. All other in_ready bits are 0. in_ready may depend combinationally on in_valid, mode, sel and out_ready.
- On a transfer (in_valid[g] && in_ready[g]):
  - out_data <= channel g data, out_src <= g, out_valid <= 1.
  - In mode 1 only, rr_ptr <= (g+1) mod NUM_IN. In mode 0, rr_ptr is unchanged.
- When load=1 and there is no grant: out_valid <= 0. out_data and out_src hold their last values.
- When out_valid=1 and out_ready=0: out_valid, out_data and out_src hold, and all in_ready are 0.
- Latency: an input accepted in cycle n appears on out_* in cycle n+1.
- Switching mode or sel takes effect on the same cycle's grant. A word already in the output register is unaffected.
- Round-robin fairness: with all NUM_IN inputs valid continuously and out_ready=1, grants cycle 0,1,…,NUM_IN-1,0…

Optional Feature:
- Macro: RR_SEL_MUX_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = XOR-reduction of the data being loaded.
  - It is registered alongside out_data, follows the same hold rules, and resets to 0.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with all in_valid=4'b1111 -> out_valid=0, out_data=0, out_src=0, in_ready=0. Release with mode=1 -> first grant is channel 0.
- Fixed select: mode=0, sel=2, in_valid=4'b0100, channel 2 data=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=32'hDEADBEEF, out_src=2. Then sel=3 with in_valid[3]=0 -> out_valid=0 on the following cycle.
- Round-robin wrap: mode=1, in_valid=4'b1111 constant, channel i data=i+1, out_ready=1 for 6 cycles -> out_src sequence 0,1,2,3,0,1 and out_data 1,2,3,4,1,2.
- Sparse RR: mode=1, rr_ptr=1, in_valid=4'b1001 -> channel 3 granted first, then channel 0, then channel 3.
- Backpressure: a word is loaded, then out_ready=0 for 3 cycles with new inputs valid -> out_data and out_src stable, in_ready=0. out_ready=1 -> the next word loads in that same cycle with no bubble.
- Parity, with macro defined: load data 32'h00000007 -> out_parity=1. Load 32'h00000003 -> out_parity=0.

Source files
------------

// File: rtl/rr_sel_mux.sv
// rr_sel_mux: N:1 datapath selector with a fixed-select or round-robin grant and a registered output stage.
// Define RR_SEL_MUX_PARITY_EN to add out_parity, the XOR of the registered data.
module rr_sel_mux #(
  parameter int DATA_W = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_src,
  input  logic                     out_ready
`ifdef RR_SEL_MUX_PARITY_EN
  ,
  output logic                     out_parity
`endif
);

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W:0]      rr_base;
  logic [SEL_W:0]      rr_sum;
  logic [2*NUM_IN-1:0] valid_dbl;
  logic [NUM_IN-1:0]   valid_rot;
  logic                load;
  logic                grant_vld;
  logic [SEL_W-1:0]    grant_idx;
  logic [DATA_W-1:0]   grant_data;
  logic [SEL_W-1:0]    ptr_next;
  mode_e               mode_q;

  assign mode_q = mode_e'(mode);

  // Nothing is accepted while reset is asserted, since that word would be discarded anyway.
  assign load = rst_n && (!out_valid || out_ready);

  // Rotating the valid vector by rr_ptr turns the wrap-around search into a lowest-bit search.
  assign rr_base   = {1'b0, rr_ptr};
  assign valid_dbl = {in_valid, in_valid};
  assign valid_rot = valid_dbl[rr_base +: NUM_IN];

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    if (mode_q == MODE_FIXED) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int k = NUM_IN - 1; k >= 0; k--) begin
        if (valid_rot[k]) begin
          grant_vld = 1'b1;
          rr_sum    = rr_base + (SEL_W+1)'(k);
        end
      end
      if (rr_sum >= NUM_IN_W) begin
        rr_sum = rr_sum - NUM_IN_W;
      end
      grant_idx = rr_sum[SEL_W-1:0];
    end
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        grant_data  = in_data[i*DATA_W +: DATA_W];
        in_ready[i] = load && grant_vld;
      end
    end
  end

  assign ptr_next = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (grant_vld) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_src   <= grant_idx;
        if (mode_q == MODE_RR) begin
          rr_ptr <= ptr_next;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RR_SEL_MUX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (load && grant_vld) begin
      out_parity <= ^grant_data;
    end
  end
`endif

endmodule

// File: tb/tb_rr_sel_mux.sv
// Testbench for rr_sel_mux: directed table, hand-written corner sequences and randomized traffic
// checked against a behavioural model of the grant/hold rules.
module tb_rr_sel_mux;

  localparam int DATA_W = 32;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  logic                     clk;
  logic                     rst_n;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_src;
  logic                     out_ready;
`ifdef RR_SEL_MUX_PARITY_EN
  logic                     out_parity;
`endif

  rr_sel_mux #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
`ifdef RR_SEL_MUX_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state.
  bit          m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  int          m_src   = 0;
  int          m_ptr   = 0;
  logic [3:0]  last_ready;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic        ordy;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_src;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_grant(output bit found, output int g);
    found = 1'b0;
    g     = 0;
    if (mode == 1'b0) begin
      if (int'(sel) < NUM_IN && in_valid[sel]) begin
        found = 1'b1;
        g     = int'(sel);
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        int idx = (m_ptr + k) % NUM_IN;
        if (!found && in_valid[idx]) begin
          found = 1'b1;
          g     = idx;
        end
      end
    end
  endfunction

  // Inputs are driven 1 time unit after a rising edge; this checks in_ready before the next
  // edge, advances the model across that edge and checks the registered outputs just after it.
  task automatic cycle();
    bit         found;
    int         g;
    logic [3:0] exp_rdy;
    #2;
    model_grant(found, g);
    exp_rdy = '0;
    if (rst_n && found && (!m_valid || out_ready)) exp_rdy[g] = 1'b1;
    last_ready = in_ready;
    check("model_in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_ptr   = 0;
    end else if (!m_valid || out_ready) begin
      if (found) begin
        m_valid = 1'b1;
        m_data  = in_data[g*DATA_W +: DATA_W];
        m_src   = g;
        if (mode) m_ptr = (g + 1) % NUM_IN;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check("model_out_valid", 64'(out_valid), 64'(m_valid));
    check("model_out_data", 64'(out_data), 64'(m_data));
    check("model_out_src", 64'(out_src), 64'(m_src));
`ifdef RR_SEL_MUX_PARITY_EN
    check("model_out_parity", 64'(out_parity), 64'(^m_data));
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = '0;
    in_valid  = 4'b1111;
    in_data   = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    out_ready = 1'b1;

    // Reset held for two clocks with every input valid.
    cycle();
    cycle();
    check("rst_in_ready", 64'(last_ready), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_src", 64'(out_src), 64'h0);
    rst_n = 1'b1;
    cycle();
    check("rst_first_grant", 64'(last_ready), 64'h1);
    check("rst_first_src", 64'(out_src), 64'h0);
    check("rst_first_valid", 64'(out_valid), 64'h1);

    // Directed table from a freshly reset state.
    rst_n = 1'b0;
    cycle();
    rst_n   = 1'b1;
    in_data = {32'h4444_0003, 32'hDEAD_BEEF, 32'h2222_0001, 32'h1111_0000};
    tbl[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 32'hDEAD_BEEF, 2'd2};
    tbl[1]  = '{1'b0, 2'd3, 4'b0100, 1'b1, 4'b0000, 1'b0, 32'hDEAD_BEEF, 2'd2};
    tbl[2]  = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 32'h1111_0000, 2'd0};
    tbl[3]  = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 32'h1111_0000, 2'd0};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'h1111_0000, 2'd0};
    tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 32'h2222_0001, 2'd1};
    tbl[6]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 32'h4444_0003, 2'd3};
    tbl[7]  = '{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010, 1'b1, 32'h2222_0001, 2'd1};
    tbl[8]  = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h2222_0001, 2'd1};
    tbl[9]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 32'hDEAD_BEEF, 2'd2};
    tbl[10] = '{1'b1, 2'd0, 4'b0011, 1'b1, 4'b0001, 1'b1, 32'h1111_0000, 2'd0};
    for (int i = 0; i < 11; i++) begin
      mode      = tbl[i].mode;
      sel       = tbl[i].sel;
      in_valid  = tbl[i].valid;
      out_ready = tbl[i].ordy;
      cycle();
      check($sformatf("tbl%0d_in_ready", i), 64'(last_ready), 64'(tbl[i].exp_ready));
      check($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_out_data", i), 64'(out_data), 64'(tbl[i].exp_data));
      check($sformatf("tbl%0d_out_src", i), 64'(out_src), 64'(tbl[i].exp_src));
    end

    // Round-robin wrap with all inputs valid.
    rst_n = 1'b0;
    cycle();
    rst_n     = 1'b1;
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in_data   = {32'd4, 32'd3, 32'd2, 32'd1};
    for (int k = 0; k < 6; k++) begin
      cycle();
      check($sformatf("rr_wrap%0d_src", k), 64'(out_src), 64'(k % 4));
      check($sformatf("rr_wrap%0d_data", k), 64'(out_data), 64'((k % 4) + 1));
    end

    // Sparse round-robin starting from rr_ptr=1.
    rst_n = 1'b0;
    cycle();
    rst_n    = 1'b1;
    in_valid = 4'b0001;
    cycle();
    in_valid = 4'b1001;
    cycle();
    check("sparse0_src", 64'(out_src), 64'd3);
    cycle();
    check("sparse1_src", 64'(out_src), 64'd0);
    cycle();
    check("sparse2_src", 64'(out_src), 64'd3);

    // Backpressure: held word stays put, then the next word loads with no bubble.
    rst_n = 1'b0;
    cycle();
    rst_n     = 1'b1;
    mode      = 1'b0;
    sel       = 2'd1;
    in_valid  = 4'b0010;
    in_data   = {32'h0, 32'h0, 32'hAAAA_0001, 32'h0};
    out_ready = 1'b1;
    cycle();
    sel       = 2'd2;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data = {32'h0, 32'hBBBB_0000 + 32'(k), 32'h0, 32'h0};
      cycle();
      check($sformatf("bp%0d_in_ready", k), 64'(last_ready), 64'h0);
      check($sformatf("bp%0d_out_data", k), 64'(out_data), 64'hAAAA_0001);
      check($sformatf("bp%0d_out_src", k), 64'(out_src), 64'd1);
    end
    out_ready = 1'b1;
    cycle();
    check("bp_release_ready", 64'(last_ready), 64'h4);
    check("bp_release_data", 64'(out_data), 64'hBBBB_0002);
    check("bp_release_src", 64'(out_src), 64'd2);

    // Reset while a word is held under backpressure.
    out_ready = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    check("midrst_out_valid", 64'(out_valid), 64'h0);
    check("midrst_out_data", 64'(out_data), 64'h0);
    rst_n = 1'b1;

`ifdef RR_SEL_MUX_PARITY_EN
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    in_data   = {96'h0, 32'h0000_0007};
    cycle();
    check("parity_7", 64'(out_parity), 64'h1);
    in_data = {96'h0, 32'h0000_0003};
    cycle();
    check("parity_3", 64'(out_parity), 64'h0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 63) != 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
